// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the PC generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_RET    = 2'b11
  } pc_sel_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_1000;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer; a push when full overwrites the oldest entry.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               ptr_q, ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  assign top   = mem_q[ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push && pop) begin
      // Pop-then-push collapses to an in-place replace of the top entry.
      mem_d[ptr_q] = din;
    end else if (push) begin
      ptr_d        = ptr_q + PW'(1);
      mem_d[ptr_d] = din;
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents carry no reset; the count alone defines validity.
  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with seq/branch/jalr/return selection and misalign rejection.
// Define PC_GEN_RAS_EN to build in the return-address stack; otherwise return acts as jalr.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       pc_sel,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] rs1,
  input  logic             is_call,
  output logic [WIDTH-1:0] pc_curr,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             misalign,
  output logic             ras_empty
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_q, pc_d, target, jalr_sum, jalr_tgt, ras_top;
  logic             misalign_q, misalign_d, reject, adv, pop_req, ras_empty_w;

  assign sel      = pc_sel_e'(pc_sel);
  assign pc_plus4 = pc_q + WIDTH'(4);
  assign jalr_sum = rs1 + imm;
  assign jalr_tgt = {jalr_sum[WIDTH-1:1], 1'b0};

  always_comb begin
    target  = pc_plus4;
    pop_req = 1'b0;
    case (sel)
      PC_BRANCH: target = pc_q + imm;
      PC_JALR:   target = jalr_tgt;
      PC_RET: begin
        if (!ras_empty_w) begin
          target  = ras_top;
          pop_req = 1'b1;
        end else begin
          target = jalr_tgt;
        end
      end
      default:   target = pc_plus4;
    endcase
  end

  // A misaligned target freezes the PC and suppresses any stack update.
  assign reject = |target[1:0];
  assign adv    = !stall && !reject;

  always_comb begin
    pc_d       = adv ? target : pc_q;
    misalign_d = stall ? misalign_q : reject;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef PC_GEN_RAS_EN
  logic push, pop, ras_full_unused;
  assign push = adv && is_call;
  assign pop  = adv && pop_req;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus4),
    .top   (ras_top),
    .empty (ras_empty_w),
    .full  (ras_full_unused)
  );
`else
  localparam int ras_depth_unused = RAS_DEPTH;
  logic ras_sig_unused;
  assign ras_sig_unused = is_call | pop_req;
  assign ras_top        = '0;
  assign ras_empty_w    = 1'b1;
`endif

  assign pc_curr   = pc_q;
  assign misalign  = misalign_q;
  assign ras_empty = ras_empty_w;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, hand sequences, and randomized run against a queue model.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk, rst, stall, is_call, misalign, ras_empty;
  logic [1:0]  pc_sel;
  logic [31:0] imm, rs1, pc_curr, pc_plus4;

  int checks = 0;
  int failures = 0;

  pc_gen dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .pc_sel    (pc_sel),
    .imm       (imm),
    .rs1       (rs1),
    .is_call   (is_call),
    .pc_curr   (pc_curr),
    .pc_plus4  (pc_plus4),
    .misalign  (misalign),
    .ras_empty (ras_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [1:0] ps, input logic [31:0] im,
                              input logic [31:0] r, input logic [31:0] p, input logic mi);
    vec_t v;
    v.stall = s; v.sel = ps; v.imm = im; v.rs1 = r; v.pc = p; v.mis = mi;
    return v;
  endfunction

  task automatic drive(input logic s, input logic [1:0] ps, input logic [31:0] im,
                       input logic [31:0] r, input logic c);
    stall = s; pc_sel = ps; imm = im; rs1 = r; is_call = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    m_pc = 32'h1000; m_mis = 1'b0; m_ras.delete();
  endtask

  // Behavioural model of one enabled edge, from the selection rules directly.
  task automatic model_step(input logic s, input logic [1:0] ps, input logic [31:0] im,
                            input logic [31:0] r, input logic c);
    logic [31:0] tgt;
    logic        do_pop;
    if (s) return;
    do_pop = 1'b0;
    case (ps)
      2'd0: tgt = m_pc + 32'd4;
      2'd1: tgt = m_pc + im;
      2'd2: tgt = (r + im) & ~32'd1;
      default: begin
        if (RAS_EN && m_ras.size() > 0) begin
          tgt = m_ras[m_ras.size()-1];
          do_pop = 1'b1;
        end else begin
          tgt = (r + im) & ~32'd1;
        end
      end
    endcase
    if (tgt[1:0] != 2'b00) begin
      m_mis = 1'b1;
      return;
    end
    m_mis = 1'b0;
    if (do_pop) void'(m_ras.pop_back());
    if (RAS_EN && c) begin
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end
    m_pc = tgt;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_sel = 2'd0; imm = '0; rs1 = '0; is_call = 1'b0;
    #12;
    chk("reset_pc", pc_curr, 32'h1000);
    chk("reset_mis", {31'd0, misalign}, 32'd0);
    chk("reset_empty", {31'd0, ras_empty}, 32'd1);
    chk("reset_plus4", pc_plus4, 32'h1004);
    #1 rst = 1'b0;

    // Directed vectors: {stall, sel, imm, rs1} -> {pc, misalign}
    tbl.push_back(mk(0, 2'd0, 32'h0,        32'h0,    32'h1004,     0));
    tbl.push_back(mk(0, 2'd0, 32'h0,        32'h0,    32'h1008,     0));
    tbl.push_back(mk(0, 2'd0, 32'h0,        32'h0,    32'h100C,     0));
    tbl.push_back(mk(0, 2'd0, 32'h0,        32'h0,    32'h1010,     0));
    tbl.push_back(mk(0, 2'd1, -32'sd16,     32'h0,    32'h1000,     0));
    tbl.push_back(mk(1, 2'd1, -32'sd16,     32'h0,    32'h1000,     0));
    tbl.push_back(mk(1, 2'd0, 32'h0,        32'h0,    32'h1000,     0));
    tbl.push_back(mk(0, 2'd2, 32'h4,        32'h2001, 32'h2004,     0));
    tbl.push_back(mk(0, 2'd2, 32'h0,        32'h2002, 32'h2004,     1));
    tbl.push_back(mk(0, 2'd0, 32'h0,        32'h0,    32'h2008,     0));
    tbl.push_back(mk(0, 2'd2, 32'h0,        32'h2002, 32'h2008,     1));
    tbl.push_back(mk(1, 2'd0, 32'h0,        32'h0,    32'h2008,     1));
    tbl.push_back(mk(0, 2'd0, 32'h0,        32'h0,    32'h200C,     0));
    tbl.push_back(mk(0, 2'd1, 32'hFFFF_DFF0, 32'h0,   32'hFFFF_FFFC, 0));
    tbl.push_back(mk(0, 2'd0, 32'h0,        32'h0,    32'h0000_0000, 0));
    tbl.push_back(mk(0, 2'd1, 32'h1000,     32'h0,    32'h1000,     0));
    tbl.push_back(mk(0, 2'd3, 32'h10,       32'h3000, 32'h3010,     0));
    tbl.push_back(mk(0, 2'd1, 32'h2,        32'h0,    32'h3010,     1));
    tbl.push_back(mk(0, 2'd1, -32'sd15,     32'h0,    32'h3010,     1));
    tbl.push_back(mk(0, 2'd0, 32'h0,        32'h0,    32'h3014,     0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].sel, tbl[i].imm, tbl[i].rs1, 1'b0);
      chk($sformatf("vec%0d_pc", i), pc_curr, tbl[i].pc);
      chk($sformatf("vec%0d_mis", i), {31'd0, misalign}, {31'd0, tbl[i].mis});
      chk($sformatf("vec%0d_plus4", i), pc_plus4, tbl[i].pc + 32'd4);
      chk($sformatf("vec%0d_empty", i), {31'd0, ras_empty}, 32'd1);
    end

`ifdef PC_GEN_RAS_EN
    // Five calls into a four-deep stack, then five returns.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 2'd1, 32'h100, 32'h0, 1'b1);
      chk($sformatf("call%0d_pc", i), pc_curr, 32'h1100 + 32'(i) * 32'h100);
      chk($sformatf("call%0d_empty", i), {31'd0, ras_empty}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'd3, 32'h0, 32'h4000, 1'b0);
      chk($sformatf("ret%0d_pc", i), pc_curr, 32'h1404 - 32'(i) * 32'h100);
    end
    drive(0, 2'd3, 32'h0, 32'h4000, 1'b0);
    chk("ret_empty_jalr_pc", pc_curr, 32'h4000);
    chk("ret_final_empty", {31'd0, ras_empty}, 32'd1);

    // Call and return together: top replaced, count unchanged.
    do_reset();
    drive(0, 2'd1, 32'h2000, 32'h0, 1'b1);
    chk("cr_setup_pc", pc_curr, 32'h3000);
    drive(0, 2'd3, 32'h0, 32'h5000, 1'b1);
    chk("cr_pc", pc_curr, 32'h1004);
    chk("cr_empty", {31'd0, ras_empty}, 32'd0);
    drive(0, 2'd3, 32'h0, 32'h5000, 1'b0);
    chk("cr_newtop", pc_curr, 32'h3004);
    chk("cr_count1", {31'd0, ras_empty}, 32'd1);

    // Stall and misalign both block a pop.
    do_reset();
    drive(0, 2'd1, 32'h100, 32'h0, 1'b1);
    drive(1, 2'd3, 32'h0, 32'h0, 1'b1);
    chk("stall_hold_pc", pc_curr, 32'h1100);
    chk("stall_no_pop", {31'd0, ras_empty}, 32'd0);
    drive(0, 2'd3, 32'h0, 32'h0, 1'b0);
    chk("after_stall_pop", pc_curr, 32'h1004);
`endif

    // Wrap-around, then an asynchronous reset in the middle of a cycle.
    do_reset();
    drive(0, 2'd1, 32'hFFFF_EFFC, 32'h0, 1'b0);
    chk("wrap_setup", pc_curr, 32'hFFFF_FFFC);
    drive(0, 2'd0, 32'h0, 32'h0, 1'b1);
    chk("wrap_pc", pc_curr, 32'h0000_0000);
    chk("wrap_plus4", pc_plus4, 32'h0000_0004);
    drive(0, 2'd1, 32'h2, 32'h0, 1'b0);
    chk("pre_rst_mis", {31'd0, misalign}, 32'd1);
    is_call = 1'b1; pc_sel = 2'd3; rs1 = 32'h7000;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", pc_curr, 32'h1000);
    chk("async_rst_mis", {31'd0, misalign}, 32'd0);
    chk("async_rst_empty", {31'd0, ras_empty}, 32'd1);
    #2 rst = 1'b0;
    drive(0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("post_rst_first", pc_curr, 32'h1004);
    chk("post_rst_empty", {31'd0, ras_empty}, 32'd1);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic        s, c;
      logic [1:0]  ps;
      logic [31:0] im, r;
      s  = ($urandom_range(0, 4) == 0);
      c  = ($urandom_range(0, 2) == 0);
      ps = 2'($urandom_range(0, 3));
      im = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (32'($urandom_range(0, 255)) << 2) - 32'h200;
      r  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom) & ~32'd3;
      drive(s, ps, im, r, c);
      model_step(s, ps, im, r, c);
      chk($sformatf("rnd%0d_pc", i), pc_curr, m_pc);
      chk($sformatf("rnd%0d_mis", i), {31'd0, misalign}, {31'd0, m_mis});
      chk($sformatf("rnd%0d_empty", i), {31'd0, ras_empty}, {31'd0, (m_ras.size() == 0)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
